// File: rtl/segment_pkg.sv
// segment_pkg
// Shared definitions for the seven-segment decoder:
//   - STABLE_CNT_DEF : default number of clocks a pattern must hold
//   - SEG_BIT/DP_BIT : bit positions of the blank flag and decimal point
//   - BLANK_PAT      : reset/blank value for synchronizers and candidates
//   - DIGIT_PAT      : segment patterns (G..A) for digits 0..9
//   - seg_state_e    : per-channel FSM state type
//   - match_digit()  : table lookup, returns {hit, digit}
package segment_pkg;

  localparam int STABLE_CNT_DEF = 16;
  localparam int SEG_BIT        = 8;
  localparam int DP_BIT         = 7;

  localparam logic [8:0] BLANK_PAT = 9'h100;
  localparam logic [8:0] DP_MASK   = 9'h080;

  // Index i holds the pattern for digit i.
  localparam logic [9:0][6:0] DIGIT_PAT = {
    7'h6f, 7'h7f, 7'h07, 7'h7d, 7'h6d,
    7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } seg_state_e;

  function automatic logic [4:0] match_digit(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 10; i++) begin
      if (DIGIT_PAT[i] == pat) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/segment_decode_ch.sv
// segment_decode_ch
// One channel of the seven-segment decoder: 2-flop synchronizer, stability
// FSM with counter, and digit-table match.
// Ports:
//   clk, rst (async, active-high)
//   pattern_i [8:0] : raw pattern {SEG, DP, G..A}, SEG=1 means blanked
//   seg_data_o[3:0] : last accepted digit
//   valid_o         : one-clock pulse on a legal settle
//   err_o           : last settled pattern was not a digit
//   dp_o            : decimal point of last accepted digit
// Build option: SEGMENT_DECODER_DP_EN registers DP on accept; otherwise DP
// is masked out and dp_o is 0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | blanked or post-reset, no candidate being timed
// ST_COUNT  | candidate loaded, counting stable clocks
// ST_LOCKED | candidate settled, outputs held until change or blank
module segment_decode_ch
  import segment_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] pattern_i,
  output logic [3:0] seg_data_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       dp_o
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

  logic [8:0] sync1_q, sync2_q;
  logic [8:0] pat_cmp;

  seg_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cand_q, cand_d;
  logic [3:0] data_q, data_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic [4:0] match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= BLANK_PAT;
      sync2_q <= BLANK_PAT;
    end else begin
      sync1_q <= pattern_i;
      sync2_q <= sync1_q;
    end
  end

  // Without DP support the DP bit must not count as a pattern change.
`ifdef SEGMENT_DECODER_DP_EN
  assign pat_cmp = sync2_q;
`else
  assign pat_cmp = sync2_q & ~DP_MASK;
`endif

  assign match = match_digit(cand_q[6:0]);

`ifdef SEGMENT_DECODER_DP_EN
  logic dp_q, dp_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
`ifdef SEGMENT_DECODER_DP_EN
    dp_d    = dp_q;
`endif
    if (pat_cmp[SEG_BIT]) begin
      // Forget the candidate so the same digit re-arms after a blank.
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      cand_d  = BLANK_PAT;
    end else if (pat_cmp != cand_q) begin
      state_d = ST_COUNT;
      cnt_d   = 8'd0;
      cand_d  = pat_cmp;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LOCKED;
            if (match[4]) begin
              data_d  = match[3:0];
              err_d   = 1'b0;
              valid_d = 1'b1;
`ifdef SEGMENT_DECODER_DP_EN
              dp_d    = cand_q[DP_BIT];
`endif
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      cand_q  <= BLANK_PAT;
      data_q  <= 4'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

`ifdef SEGMENT_DECODER_DP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dp_q <= 1'b0;
    else     dp_q <= dp_d;
  end
  assign dp_o = dp_q;
`else
  assign dp_o = 1'b0;
`endif

  assign seg_data_o = data_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;

endmodule

// File: rtl/segment_decoder.sv
// segment_decoder
// Two independent seven-segment pattern decoders with stability filtering.
// Ports:
//   clk, rst (async, active-high)
//   segment_led_1/2 [8:0] : {SEG, DP, G, F, E, D, C, B, A}, SEG=1 blanked
//   seg_data_1/2   [3:0]  : last accepted digit per channel
//   seg_valid      [1:0]  : one-clock accept pulse, bit0 = channel 1
//   seg_err        [1:0]  : last settled pattern was not a digit
//   dp             [1:0]  : decimal point per channel
// Build option: define SEGMENT_DECODER_DP_EN to decode DP; otherwise dp = 0.
module segment_decoder
  import segment_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] segment_led_1,
  input  logic [8:0] segment_led_2,
  output logic [3:0] seg_data_1,
  output logic [3:0] seg_data_2,
  output logic [1:0] seg_valid,
  output logic [1:0] seg_err,
  output logic [1:0] dp
);

  segment_decode_ch #(.STABLE_CNT(STABLE_CNT)) u_ch1 (
    .clk        (clk),
    .rst        (rst),
    .pattern_i  (segment_led_1),
    .seg_data_o (seg_data_1),
    .valid_o    (seg_valid[0]),
    .err_o      (seg_err[0]),
    .dp_o       (dp[0])
  );

  segment_decode_ch #(.STABLE_CNT(STABLE_CNT)) u_ch2 (
    .clk        (clk),
    .rst        (rst),
    .pattern_i  (segment_led_2),
    .seg_data_o (seg_data_2),
    .valid_o    (seg_valid[1]),
    .err_o      (seg_err[1]),
    .dp_o       (dp[1])
  );

endmodule
